// File: rtl/cc_pkg.sv
// Shared definitions for the two-requester AXI read arbiter.
// Holds AXI field widths, the AR FSM state type and the AR payload bundle.
package cc_pkg;

    localparam int ID_W    = 4;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int DATA_W  = 64;
    localparam int RESP_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD0 = 2'd1,
        ST_HOLD1 = 2'd2
    } ar_state_e;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } ar_t;

    // Winner between two requesters; prio names the favoured one on a tie.
    function automatic logic rr_pick(
        input logic v0,
        input logic v1,
        input logic prio
    );
        return (v0 && v1) ? prio : v1;
    endfunction

endpackage

// File: rtl/cc_fifo.sv
// Small synchronous FIFO with count-based full/almost-full/empty flags.
// Used by the arbiter to remember which requester owns each burst in flight.
module cc_fifo #(
    parameter int DATA_WIDTH      = 1,
    parameter int FIFO_DEPTH      = 4,
    parameter int AFULL_THRESHOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  afull_o,
    output logic                  empty_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    assign full_o  = (r_count == CW'(FIFO_DEPTH));
    assign afull_o = (r_count >= CW'(AFULL_THRESHOLD));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign data_o  = r_mem[r_rptr];

    // Storage write on accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cc_mem_arbiter.sv
// Two-requester AXI read arbiter in front of one in-order memory port.
// AR is round-robin with a captured payload; R is routed by owner-queue head.
module cc_mem_arbiter
    import cc_pkg::*;
#(
    parameter int OWNER_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic [ID_W-1:0]          rq0_arid_i,
    input  logic [ADDR_W-1:0]        rq0_araddr_i,
    input  logic [LEN_W-1:0]         rq0_arlen_i,
    input  logic [SIZE_W-1:0]        rq0_arsize_i,
    input  logic [BURST_W-1:0]       rq0_arburst_i,
    input  logic                     rq0_arvalid_i,
    output logic                     rq0_arready_o,
    output logic [ID_W-1:0]          rq0_rid_o,
    output logic [DATA_W-1:0]        rq0_rdata_o,
    output logic [RESP_W-1:0]        rq0_rresp_o,
    output logic                     rq0_rlast_o,
    output logic                     rq0_rvalid_o,
    input  logic                     rq0_rready_i,

    input  logic [ID_W-1:0]          rq1_arid_i,
    input  logic [ADDR_W-1:0]        rq1_araddr_i,
    input  logic [LEN_W-1:0]         rq1_arlen_i,
    input  logic [SIZE_W-1:0]        rq1_arsize_i,
    input  logic [BURST_W-1:0]       rq1_arburst_i,
    input  logic                     rq1_arvalid_i,
    output logic                     rq1_arready_o,
    output logic [ID_W-1:0]          rq1_rid_o,
    output logic [DATA_W-1:0]        rq1_rdata_o,
    output logic [RESP_W-1:0]        rq1_rresp_o,
    output logic                     rq1_rlast_o,
    output logic                     rq1_rvalid_o,
    input  logic                     rq1_rready_i,

    output logic [ID_W-1:0]          mem_arid_o,
    output logic [ADDR_W-1:0]        mem_araddr_o,
    output logic [LEN_W-1:0]         mem_arlen_o,
    output logic [SIZE_W-1:0]        mem_arsize_o,
    output logic [BURST_W-1:0]       mem_arburst_o,
    output logic                     mem_arvalid_o,
    input  logic                     mem_arready_i,

    input  logic [ID_W-1:0]          mem_rid_i,
    input  logic [DATA_W-1:0]        mem_rdata_i,
    input  logic [RESP_W-1:0]        mem_rresp_i,
    input  logic                     mem_rlast_i,
    input  logic                     mem_rvalid_i,
    output logic                     mem_rready_o,

    output logic [$clog2(OWNER_DEPTH):0] outstanding_o,
    output logic                     orphan_err_o
);

    localparam int OW = $clog2(OWNER_DEPTH) + 1;

    ar_state_e     r_state;
    ar_t           r_ar;
    logic          r_mem_arvalid;
    logic          r_rr_prio;
    logic          r_orphan;
    logic [OW-1:0] r_outstanding;

    ar_t           w_rq0_ar;
    ar_t           w_rq1_ar;
    logic          w_full;
    logic          w_afull;
    logic          w_empty;
    logic          w_head;
    logic          w_nonempty;
    logic          w_sel;
    logic          w_sel_valid;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    assign w_rq0_ar = '{id: rq0_arid_i, addr: rq0_araddr_i,
                        len: rq0_arlen_i, size: rq0_arsize_i,
                        burst: rq0_arburst_i};
    assign w_rq1_ar = '{id: rq1_arid_i, addr: rq1_araddr_i,
                        len: rq1_arlen_i, size: rq1_arsize_i,
                        burst: rq1_arburst_i};

    // Capture is offered only from IDLE with room left in the owner queue;
    // rst_n gating keeps arready low while reset is held.
    assign w_sel       = rr_pick(rq0_arvalid_i, rq1_arvalid_i, r_rr_prio);
    assign w_sel_valid = rst_n && (r_state == ST_IDLE) && !w_full &&
                         (rq0_arvalid_i || rq1_arvalid_i);

    assign rq0_arready_o = w_sel_valid && !w_sel;
    assign rq1_arready_o = w_sel_valid && w_sel;

    assign mem_arid_o    = r_ar.id;
    assign mem_araddr_o  = r_ar.addr;
    assign mem_arlen_o   = r_ar.len;
    assign mem_arsize_o  = r_ar.size;
    assign mem_arburst_o = r_ar.burst;
    assign mem_arvalid_o = r_mem_arvalid;

    assign w_push = r_mem_arvalid && mem_arready_i;

    // R routing follows the oldest outstanding burst; mem_rid_i is ignored.
    assign w_nonempty   = (r_outstanding != '0);
    assign mem_rready_o = w_nonempty &&
                          (w_head ? rq1_rready_i : rq0_rready_i);
    assign w_pop        = mem_rvalid_i && mem_rready_o && mem_rlast_i;

    assign rq0_rvalid_o = w_nonempty && !w_head && mem_rvalid_i;
    assign rq1_rvalid_o = w_nonempty && w_head && mem_rvalid_i;
    assign rq0_rid_o    = mem_rid_i;
    assign rq0_rdata_o  = mem_rdata_i;
    assign rq0_rresp_o  = mem_rresp_i;
    assign rq0_rlast_o  = mem_rlast_i;
    assign rq1_rid_o    = mem_rid_i;
    assign rq1_rdata_o  = mem_rdata_i;
    assign rq1_rresp_o  = mem_rresp_i;
    assign rq1_rlast_o  = mem_rlast_i;

    assign outstanding_o = r_outstanding;
    assign orphan_err_o  = r_orphan;

    assign w_unused = &{1'b0, w_afull, w_empty};

    cc_fifo #(
        .DATA_WIDTH      (1),
        .FIFO_DEPTH      (OWNER_DEPTH),
        .AFULL_THRESHOLD (OWNER_DEPTH)
    ) u_owner_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .data_i  (r_state == ST_HOLD1),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .afull_o (w_afull),
        .empty_o (w_empty)
    );

    // AR FSM: capture winner, hold payload until memory accepts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ar          <= '0;
            r_mem_arvalid <= 1'b0;
            r_rr_prio     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_ar          <= w_sel ? w_rq1_ar : w_rq0_ar;
                        r_state       <= w_sel ? ST_HOLD1 : ST_HOLD0;
                        r_mem_arvalid <= 1'b1;
                    end
                end
                ST_HOLD0, ST_HOLD1: begin
                    if (mem_arready_i) begin
                        r_state       <= ST_IDLE;
                        r_mem_arvalid <= 1'b0;
                        r_rr_prio     <= (r_state == ST_HOLD0);
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_mem_arvalid <= 1'b0;
                end
            endcase
        end
    end

    // Count of bursts granted on AR and not yet finished on R
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Sticky flag for R beats that arrive with nobody owning them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_orphan <= 1'b0;
        end else if (mem_rvalid_i && !w_nonempty) begin
            r_orphan <= 1'b1;
        end
    end

endmodule

// File: doc/cc_mem_arbiter.md
CC_MEM_ARBITER -- requirements
Module: cc_mem_arbiter

Interface
REQ-001 Parameter OWNER_DEPTH, default 4: maximum outstanding memory bursts; power of two, at least 2.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 rq{0,1}_arid_i / araddr_i / arlen_i / arsize_i / arburst_i  in  4/32/4/3/2  per-requester AXI AR payload.
REQ-005 rq{0,1}_arvalid_i  in  1; rq{0,1}_arready_o  out  1  per-requester AR handshake.
REQ-006 rq{0,1}_rid_o / rdata_o / rresp_o / rlast_o / rvalid_o  out  4/64/2/1/1; rq{0,1}_rready_i  in  1  per-requester R channel.
REQ-007 mem_arid_o / araddr_o / arlen_o / arsize_o / arburst_o / arvalid_o  out  4/32/4/3/2/1; mem_arready_i  in  1  shared memory AR.
REQ-008 mem_rid_i / rdata_i / rresp_i / rlast_i / rvalid_i  in  4/64/2/1/1; mem_rready_o  out  1  shared memory R.
REQ-009 outstanding_o  out  $clog2(OWNER_DEPTH)+1  bursts granted on AR and not yet completed on R.
REQ-010 orphan_err_o  out  1  sticky flag: memory R beat arrived with no outstanding burst.

Function
REQ-011 AR FSM states: IDLE, HOLD0, HOLD1; reset state is IDLE.
REQ-012 IDLE: if owner queue not full and any arvalid, select per round-robin priority; go to HOLD<n> on the next edge.
REQ-013 Round-robin: the requester not most recently granted has priority; after reset, rq0 has priority.
REQ-014 HOLD<n>: mem_arvalid_o=1 and mem_ar* = registered copy of rq<n> payload captured on entry; payload stable until handshake.
REQ-015 rq<n>_arready_o is a one-cycle pulse on the IDLE->HOLD<n> capture edge; the requester sees its handshake at capture, not at the memory handshake.
REQ-016 HOLD<n> with mem_arready_i=1: push n into owner queue, update the round-robin pointer, return to IDLE; one grant per 2 cycles maximum.
REQ-017 Owner queue full: no capture, both arready_o=0, FSM remains IDLE.
REQ-018 Memory returns bursts in AR issue order; R routing uses the owner-queue head only, never mem_rid_i.
REQ-019 R path is combinational: rq<h>_r*_o = mem_r*_i, rq<h>_rvalid_o = mem_rvalid_i, where h = queue head and queue non-empty; the other requester's rvalid_o = 0.
REQ-020 mem_rready_o = rq<h>_rready_i when queue non-empty, else 0.
REQ-021 Beat with mem_rvalid_i & mem_rready_o & mem_rlast_i pops the owner queue.
REQ-022 Simultaneous push (AR handshake) and pop (last beat) in one cycle: both take effect, and outstanding_o is unchanged.
REQ-023 mem_rvalid_i=1 with empty queue: set orphan_err_o (cleared only by reset); beat not accepted.
REQ-024 Requester arvalid withdrawn before capture: no grant and no state change.

Reset
REQ-025 On rst_n low, immediately: FSM IDLE, queue empty, RR pointer to rq0, orphan_err_o=0, outstanding_o=0, all arready/arvalid/rvalid/rready outputs 0.
REQ-026 Reset mid-burst discards all outstanding ownership; beats arriving after reset release set orphan_err_o.

Structure
REQ-027 AR FSM state enum and the AXI field widths (ID 4, ADDR 32, LEN 4, SIZE 3, BURST 2, DATA 64) reside in shared package cc_pkg.
REQ-028 Owner queue is one instance of CC_FIFO: DATA_WIDTH 1, FIFO_DEPTH OWNER_DEPTH, AFULL_THRESHOLD OWNER_DEPTH. Full is taken from full_o; all other logic is inline.

Verification
REQ-029 Sequence:
- rq0 issues araddr 0x1000, arlen 3.
- Memory returns 4 beats.
- Required: rq0 sees 4 beats with rlast on beat 4, rq1_rvalid_o stays 0, outstanding_o goes 1 then 0.
REQ-030 Sequence:
- Both arvalid held continuously.
- rq0 sends araddr 0x100, 0x200, 0x300; rq1 sends araddr 0x900, 0xA00, 0xB00.
- Required: mem_araddr_o order is 0x100, 0x900, 0x200, 0xA00, 0x300, 0xB00.
REQ-031 Sequence:
- Hold mem_arready_i low 5 cycles during HOLD0.
- Required: mem_ar* stable for all 5 cycles, no second capture, grant completes on the 6th cycle.
REQ-032 Sequence:
- OWNER_DEPTH=4; issue 5 ARs with mem_rvalid_i held 0.
- Required: 4 handshakes, 5th arready_o stays 0, outstanding_o=4.
- After one rlast, the 5th is captured.
REQ-033 Sequence:
- rq1_rready_i toggles 1,0,1,0 during a 4-beat rq1 burst.
- Required: mem_rready_o mirrors rq1_rready_i each cycle and no beat is lost.
- Same-cycle last-beat pop and AR push leaves outstanding_o unchanged.
REQ-034 Sequence:
- Drive mem_rvalid_i=1 after reset with no AR issued.
- Required: orphan_err_o=1 next cycle, mem_rready_o=0, flag held until rst_n low.
